// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (D-cache m0, I-cache m1) arbiter in front of a
// single shared data-memory port. One transaction is in flight at a time:
// IDLE picks a winner and latches its request, BUSY presents it to memory
// until mem_ack_i, and DONE inserts one dead cycle so the finished
// requester can drop its enable before the next arbitration.
//
// Optional feature: define MEM_ARBITER_RR_EN for round-robin arbitration
// on contention. Without it, master 0 has fixed priority.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   mN_enable_i / mN_write_i     request and write flag (N = 0, 1)
//   mN_addr_i / mN_data_i        line address and write line
//   mN_data_o / mN_ack_o         returned line and one-cycle completion
//   mem_enable_o / mem_write_o   shared memory request and write flag
//   mem_addr_o / mem_data_o      shared memory address and write line
//   mem_data_i / mem_ack_i       memory read line and completion pulse
//   grant_cnt0_o / grant_cnt1_o  saturating per-master grant counts
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [15:0]       grant_cnt0_o,
  output logic [15:0]       grant_cnt1_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              write_q;
  logic              winner_q;
  logic [CNT_W-1:0]  grant_cnt0_q;
  logic [CNT_W-1:0]  grant_cnt1_q;
`ifdef MEM_ARBITER_RR_EN
  logic              last_q;
`endif

  logic any_req;
  logic pick;
  logic busy;

  // Winner select: 0 = D-cache, 1 = I-cache. A lone requester always wins.
  always_comb begin
    any_req = m0_enable_i | m1_enable_i;
    pick    = ~m0_enable_i;
`ifdef MEM_ARBITER_RR_EN
    if (m0_enable_i && m1_enable_i) begin
      pick = ~last_q;
    end
`endif
  end

  // Transaction FSM, request latch and grant counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      winner_q     <= 1'b0;
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state    <= BUSY;
            winner_q <= pick;
            addr_q   <= pick ? m1_addr_i  : m0_addr_i;
            data_q   <= pick ? m1_data_i  : m0_data_i;
            write_q  <= pick ? m1_write_i : m0_write_i;
`ifdef MEM_ARBITER_RR_EN
            last_q   <= pick;
`endif
            if (!pick) begin
              if (grant_cnt0_q != CNT_MAX) grant_cnt0_q <= grant_cnt0_q + CNT_W'(1);
            end else begin
              if (grant_cnt1_q != CNT_MAX) grant_cnt1_q <= grant_cnt1_q + CNT_W'(1);
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) state <= DONE;
        end
        DONE: begin
          // Dead cycle: requests are ignored so the finished master can drop enable.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);

  // Memory side only carries the latched request while BUSY.
  assign mem_enable_o = busy;
  assign mem_write_o  = busy & write_q;
  assign mem_addr_o   = busy ? addr_q : '0;
  assign mem_data_o   = busy ? data_q : '0;

  // Ack and read data pass straight through to the winner in the ack cycle.
  assign m0_ack_o  = busy & mem_ack_i & ~winner_q;
  assign m1_ack_o  = busy & mem_ack_i & winner_q;
  assign m0_data_o = (busy && !winner_q) ? mem_data_i : '0;
  assign m1_data_o = (busy && winner_q)  ? mem_data_i : '0;

  assign grant_cnt0_o = grant_cnt0_q;
  assign grant_cnt1_o = grant_cnt1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a scoreboard.
// The stimulus process queues expected memory requests and expected acks;
// a negedge monitor pops and compares whenever the DUT raises mem_enable_o
// or an mN_ack_o. A responder process models the memory latency.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
  logic          m0_ack_o, m1_ack_o;
  logic          mem_enable_o, mem_write_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic [15:0]   grant_cnt0_o, grant_cnt1_o;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .grant_cnt0_o(grant_cnt0_o), .grant_cnt1_o(grant_cnt1_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; } req_t;
  typedef struct { logic idx; logic [DW-1:0] rdata; } ack_t;

  req_t req_q[$];
  ack_t ack_q[$];

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            acks_seen = 0;
  int            mem_lat = 0;
  bit            resp_en = 1'b0;
  bit            stray_ack = 1'b0;
  bit            b2b_chk = 1'b0;
  logic [DW-1:0] rd_line = '0;
  logic [15:0]   exp_cnt0 = '0;
  logic [15:0]   exp_cnt1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic expect_txn(input logic idx, input logic [AW-1:0] addr, input logic wr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    req_t r;
    ack_t a;
    r.addr = addr; r.wr = wr; r.wdata = wdata;
    req_q.push_back(r);
    a.idx = idx; a.rdata = rdata;
    ack_q.push_back(a);
    if (idx) exp_cnt1 = sat_inc(exp_cnt1);
    else     exp_cnt0 = sat_inc(exp_cnt0);
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (acks_seen < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (acks_seen < target) begin
      fails++;
      $display("FAIL %s timeout: acks %0d expected %0d", name, acks_seen, target);
    end
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_cnt0"}, DW'(grant_cnt0_o), DW'(exp_cnt0));
    chk({name, "_cnt1"}, DW'(grant_cnt1_o), DW'(exp_cnt1));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_mem_en"},   DW'(mem_enable_o), '0);
    chk({name, "_mem_wr"},   DW'(mem_write_o), '0);
    chk({name, "_mem_addr"}, DW'(mem_addr_o), '0);
    chk({name, "_mem_data"}, mem_data_o, '0);
    chk({name, "_acks"},     DW'({m0_ack_o, m1_ack_o}), '0);
    chk({name, "_m0_data"},  m0_data_o, '0);
    chk({name, "_m1_data"},  m1_data_o, '0);
    chk({name, "_cnt0"},     DW'(grant_cnt0_o), '0);
    chk({name, "_cnt1"},     DW'(grant_cnt1_o), '0);
  endtask

  // Memory model: acks after mem_lat BUSY cycles; stray_ack injects acks.
  initial begin : responder
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      mem_data_i = rd_line;
      if (resp_en && mem_enable_o && wait_cnt >= mem_lat) begin
        mem_ack_i = 1'b1;
        wait_cnt  = 0;
      end else begin
        mem_ack_i = stray_ack;
        if (resp_en && mem_enable_o) wait_cnt++;
        else                         wait_cnt = 0;
      end
    end
  end

  // Monitor: scoreboard pops on each new memory request and each ack.
  initial begin : monitor
    bit   prev_en, prev_ack, win_ack;
    int   last_ack;
    req_t cur;
    ack_t a;
    prev_en = 1'b0; prev_ack = 1'b0; win_ack = 1'b0; last_ack = 0;
    cur.addr = '0; cur.wr = 1'b0; cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (!b2b_chk) win_ack = 1'b0;
      if (mem_enable_o && !prev_en) begin
        if (b2b_chk && win_ack) chk("b2b_gap", DW'(cyc - last_ack), DW'(3));
        if (req_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_request: addr %0h, none expected", mem_addr_o);
        end else begin
          cur = req_q.pop_front();
        end
      end
      if (mem_enable_o) begin
        chk("mem_addr",  DW'(mem_addr_o), DW'(cur.addr));
        chk("mem_write", DW'(mem_write_o), DW'(cur.wr));
        chk("mem_data",  mem_data_o, cur.wdata);
      end else begin
        chk("idle_mem_bus", DW'({mem_write_o, mem_addr_o}), '0);
        chk("idle_mem_data", mem_data_o, '0);
        chk("idle_rd_data", m0_data_o | m1_data_o, '0);
      end
      if (m0_ack_o || m1_ack_o) begin
        acks_seen++;
        last_ack = cyc;
        if (b2b_chk) win_ack = 1'b1;
        chk("ack_pulse", DW'(prev_ack), '0);
        if (ack_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ack: m0 %0b m1 %0b, none expected", m0_ack_o, m1_ack_o);
        end else begin
          a = ack_q.pop_front();
          chk("ack_onehot", DW'(m0_ack_o & m1_ack_o), '0);
          chk("ack_idx",    DW'(m1_ack_o), DW'(a.idx));
          chk("ack_data",   a.idx ? m1_data_o : m0_data_o, a.rdata);
          chk("loser_data", a.idx ? m0_data_o : m1_data_o, '0);
        end
      end
      prev_ack = m0_ack_o | m1_ack_o;
      prev_en  = mem_enable_o;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DW-1:0] a5;
    logic          w;
    int            tgt;
    int            n;
    a5 = {32{8'hA5}};
    rst_i = 1'b1;
    m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
    m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
    mem_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    rst_i = 1'b0;
    resp_en = 1'b1;
    @(posedge clk); #1;
    chk_counts("after_reset");

    // Single read from m0.
    rd_line = a5; mem_lat = 10;
    expect_txn(1'b0, 32'h0000_0400, 1'b0, '0, a5);
    tgt = acks_seen + 1;
    m0_addr_i = 32'h0000_0400; m0_write_i = 1'b0; m0_data_i = '0; m0_enable_i = 1'b1;
    wait_acks(tgt, 40, "single_read");
    m0_enable_i = 1'b0;
    chk_counts("single_read");
    repeat (3) @(posedge clk); #1;

    // Write from m1.
    rd_line = {8{32'hDEAD_BEEF}}; mem_lat = 3;
    expect_txn(1'b1, 32'h0000_0820, 1'b1, DW'(16'h1234), {8{32'hDEAD_BEEF}});
    tgt = acks_seen + 1;
    m1_addr_i = 32'h0000_0820; m1_write_i = 1'b1; m1_data_i = DW'(16'h1234); m1_enable_i = 1'b1;
    wait_acks(tgt, 40, "write");
    m1_enable_i = 1'b0;
    chk_counts("write");
    repeat (3) @(posedge clk); #1;

    // Contention: both held for four transactions, back-to-back spacing checked.
    rd_line = {64{4'h5}}; mem_lat = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_RR_EN
      w = (i % 2 == 1);
`else
      w = 1'b0;
`endif
      if (w) expect_txn(1'b1, 32'h0000_2000, 1'b1, {8{32'h0BAD_F00D}}, {64{4'h5}});
      else   expect_txn(1'b0, 32'h0000_1000, 1'b0, {8{32'h1111_2222}}, {64{4'h5}});
    end
    tgt = acks_seen + 4;
    b2b_chk = 1'b1;
    m0_addr_i = 32'h0000_1000; m0_write_i = 1'b0; m0_data_i = {8{32'h1111_2222}};
    m1_addr_i = 32'h0000_2000; m1_write_i = 1'b1; m1_data_i = {8{32'h0BAD_F00D}};
    m0_enable_i = 1'b1; m1_enable_i = 1'b1;
    wait_acks(tgt, 100, "contention");
    m0_enable_i = 1'b0; m1_enable_i = 1'b0;
    b2b_chk = 1'b0;
    chk_counts("contention");
    repeat (3) @(posedge clk); #1;

    // Stray acks while IDLE.
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_ack", DW'({m0_ack_o, m1_ack_o}), '0);
    end
    @(posedge clk); #1;
    stray_ack = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of a BUSY m0 read.
    begin
      req_t r;
      r.addr = 32'h0000_3000; r.wr = 1'b0; r.wdata = '0;
      req_q.push_back(r);
    end
    mem_lat = 20;
    m0_addr_i = 32'h0000_3000; m0_write_i = 1'b0; m0_data_i = '0; m0_enable_i = 1'b1;
    n = 0;
    while (!mem_enable_o && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reset_busy_reached", DW'(mem_enable_o), DW'(1));
    repeat (2) @(posedge clk); #1;
    resp_en = 1'b0; stray_ack = 1'b1;
    rst_i = 1'b1; m0_enable_i = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset_a");
    @(negedge clk);
    chk_all_zero("mid_reset_b");
    @(posedge clk); #1;
    rst_i = 1'b0; stray_ack = 1'b0; resp_en = 1'b1; mem_lat = 0;
    exp_cnt0 = '0; exp_cnt1 = '0;
    chk_counts("post_reset");
    expect_txn(1'b0, 32'h0000_3100, 1'b0, '0, {64{4'h5}});
    tgt = acks_seen + 1;
    m0_addr_i = 32'h0000_3100; m1_addr_i = 32'h0000_3200; m1_write_i = 1'b0; m1_data_i = '0;
    m0_enable_i = 1'b1; m1_enable_i = 1'b1;
    wait_acks(tgt, 40, "post_reset_grant");
    m0_enable_i = 1'b0; m1_enable_i = 1'b0;
    chk_counts("post_reset_grant");
    repeat (3) @(posedge clk); #1;

    // Saturation: preload the m0 counter near the top, then keep granting.
    force dut.grant_cnt0_q = 16'hFFFC;
    @(posedge clk); #1;
    release dut.grant_cnt0_q;
    exp_cnt0 = 16'hFFFC;
    chk_counts("sat_preload");
    rd_line = {16{16'hC0DE}}; mem_lat = 0;
    for (int i = 0; i < 6; i++) begin
      expect_txn(1'b0, 32'h0000_4000 + AW'(i * 32), 1'b0, '0, {16{16'hC0DE}});
      tgt = acks_seen + 1;
      m0_addr_i = 32'h0000_4000 + AW'(i * 32); m0_data_i = '0; m0_enable_i = 1'b1;
      wait_acks(tgt, 20, "saturation");
      m0_enable_i = 1'b0;
      chk_counts("saturation");
    end
    repeat (4) @(posedge clk); #1;

    chk("req_q_drained", DW'(req_q.size()), '0);
    chk("ack_q_drained", DW'(ack_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 256, cache-line width.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports m0_enable_i, m0_write_i (input, 1 each), D-cache request and write flag; enable held high until m0_ack_o.
REQ-006 SHALL have ports m0_addr_i (input, ADDR_W) and m0_data_i (input, DATA_W), D-cache line address and write line.
REQ-007 SHALL have ports m0_data_o (output, DATA_W) and m0_ack_o (output, 1), read line returned and one-cycle completion pulse.
REQ-008 SHALL have ports m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o, I-cache request port, identical widths and meaning to port 0.
REQ-009 SHALL have ports mem_enable_o, mem_write_o (output, 1), mem_addr_o (output, ADDR_W), mem_data_o (output, DATA_W), shared data-memory request.
REQ-010 SHALL have ports mem_data_i (input, DATA_W) and mem_ack_i (input, 1), memory read line and completion pulse.
REQ-011 SHALL have ports grant_cnt0_o, grant_cnt1_o (output, 16 each), saturating granted-transaction counts.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 SHALL, in IDLE, when any mN_enable_i is high, select one winner, register its addr/data/write flag and index, and enter BUSY on the next edge.
REQ-014 SHALL, in IDLE with no request, stay in IDLE.
REQ-015 SHALL drive mem_enable_o high and mem_addr_o/mem_data_o/mem_write_o from the registered values only while in BUSY; all four SHALL be 0 otherwise.
REQ-016 SHALL, in BUSY with mem_ack_i high, assert the winner's mN_ack_o in that same cycle and enter DONE.
REQ-017 SHALL drive the winner's mN_data_o = mem_data_i while in BUSY; mN_data_o SHALL be 0 otherwise and the loser's always 0.
REQ-018 SHALL ignore mem_ack_i outside BUSY; no mN_ack_o pulses there.
REQ-019 SHALL leave DONE for IDLE unconditionally after one cycle, ignoring requests, so the completed requester can drop enable.
REQ-020 SHALL keep a latched transaction running to ack even if the winner drops mN_enable_i early; the ack is still forwarded.
REQ-021 SHALL deliver latency: request first seen in IDLE at cycle n -> mem_enable_o high at n+1; ack at cycle k -> mem_enable_o low at k+1 -> earliest next mem_enable_o at k+3.
REQ-022 SHALL increment grant_cntN_o by 1 on each IDLE->BUSY grant to master N, saturating at 16'hFFFF.
REQ-023 SHALL, on simultaneous requests, resolve per the Configuration section; a single requester always wins.

Reset
REQ-024 SHALL, while rst_i is high, asynchronously force state IDLE, grant counters 0, registered addr/data/write 0, last-winner pointer to master 1.
REQ-025 SHALL hold every output at 0 during reset, including when rst_i asserts mid-BUSY; the in-flight transaction is dropped with no ack.

Configuration
REQ-026 SHALL, with macro MEM_ARBITER_RR_EN defined, arbitrate round-robin: on contention, grant the master not granted last; last-winner pointer updated at every grant.
REQ-027 SHALL, without MEM_ARBITER_RR_EN, arbitrate fixed priority: master 0 (D-cache) always wins contention; pointer unused.

Verification
REQ-028 SHALL verify single read: m0 read addr 32'h0000_0400, ack after 10 cycles with line 256'hA5..A5 -> mem_addr_o=32'h400, mem_write_o=0, m0_ack_o one-cycle, m0_data_o=A5..A5, grant_cnt0_o=1.
REQ-029 SHALL verify write pass-through: m1 write addr 32'h0000_0820, data 256'h1234 -> mem_write_o=1, mem_data_o=256'h1234 throughout BUSY, m1_ack_o on ack.
REQ-030 SHALL verify contention: m0 and m1 held high for 4 transactions -> RR_EN grants 0,1,0,1; no RR_EN grants 0,0,0,0 with m1 starved.
REQ-031 SHALL verify spacing: back-to-back requests -> mem_enable_o low for exactly 2 cycles between ack and next enable.
REQ-032 SHALL verify reset mid-BUSY: rst_i high 2 cycles during BUSY -> all outputs 0, no ack, counters 0, then first contended grant goes to m0.
REQ-033 SHALL verify stray ack and saturation: mem_ack_i pulsed in IDLE -> no mN_ack_o; 65,540 m0 grants -> grant_cnt0_o stays 16'hFFFF.
